// File: rtl/aes_text_in_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_text_in_loader_if                                                    |
// | Valid/ready word stream feeding the AES plaintext block loader.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface aes_text_in_loader_if #(
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/aes_text_in_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_text_in_loader                                                       |
// | Assembles WORD_W-bit plaintext words MSB-first into the 128-bit block    |
// | register, pulses core_ld, then waits for core_done before refilling.     |
// | Optional macro AES_TEXT_IN_BYTESWAP_EN byte-reverses each input word.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes_text_in_loader #(
  parameter int WORD_W = 32
) (
  input  wire           clk,
  input  wire           rst,
  aes_text_in_loader_if.slave in_if,
  output logic          core_ld,
  input  wire           core_done,
  output logic [127:0]  text_in_r,
  output logic          busy,
  output logic          err_done
);

  localparam int N_WORDS = 128 / WORD_W;
  localparam int CNT_W   = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [127:0]       asm_q, asm_nxt;
  logic [127:0]       text_nxt;
  logic               ready, ready_nxt;
  logic               ld_nxt;
  logic               err_nxt;
  logic               accept;
  wire  [WORD_W-1:0]  word;

`ifdef AES_TEXT_IN_BYTESWAP_EN
  // Little-endian bus: lowest input byte lands in the most significant slot.
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_swap
    assign word[8*b +: 8] = in_if.in_data[WORD_W-8-8*b +: 8];
  end
`else
  assign word = in_if.in_data;
`endif

  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid & ready;
  assign busy           = (state != S_FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      cnt       <= '0;
      asm_q     <= '0;
      text_in_r <= '0;
      ready     <= 1'b0;
      core_ld   <= 1'b0;
      err_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      asm_q     <= asm_nxt;
      text_in_r <= text_nxt;
      ready     <= ready_nxt;
      core_ld   <= ld_nxt;
      err_done  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    asm_nxt   = asm_q;
    text_nxt  = text_in_r;
    ready_nxt = ready;
    ld_nxt    = 1'b0;
    err_nxt   = err_done;

    case (state)
      S_FILL: begin
        ready_nxt = 1'b1;
        if (core_done) err_nxt = 1'b1;
        if (accept) begin
          asm_nxt = {asm_q[127-WORD_W:0], word};
          if (cnt == LAST_CNT) begin
            text_nxt  = {asm_q[127-WORD_W:0], word};
            cnt_nxt   = '0;
            ready_nxt = 1'b0;
            ld_nxt    = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_LOAD: begin
        // A done arriving here is spurious but must not stall the hand-off.
        if (core_done) err_nxt = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          ready_nxt = 1'b1;
          state_nxt = S_FILL;
        end
      end
      default: begin
        state_nxt = S_FILL;
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_text_in_loader.sv
`default_nettype none
// Bench for aes_text_in_loader: a 32-bit and an 8-bit instance, directed steps,
// expected blocks queued at stimulus time and matched whenever core_ld fires.
module tb_aes_text_in_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         core_done, core_done8;
  logic         core_ld, busy, err_done;
  logic         core_ld8, busy8, err_done8;
  logic [127:0] text, text8;

  aes_text_in_loader_if #(.WORD_W(32)) bus ();
  aes_text_in_loader_if #(.WORD_W(8))  bus8 ();

  aes_text_in_loader #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .in_if(bus.slave), .core_ld(core_ld),
    .core_done(core_done), .text_in_r(text), .busy(busy), .err_done(err_done)
  );

  aes_text_in_loader #(.WORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_if(bus8.slave), .core_ld(core_ld8),
    .core_done(core_done8), .text_in_r(text8), .busy(busy8), .err_done(err_done8)
  );

  localparam logic [127:0] FIPS = 128'h00112233445566778899aabbccddeeff;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] q32[$];
  logic [127:0] q8[$];
  logic         prev_ld  = 1'b0;
  logic         prev_ld8 = 1'b0;
  logic [127:0] exp_blk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word as it ends up inside the block register.
  function automatic logic [31:0] packed_word(input logic [31:0] w);
`ifdef AES_TEXT_IN_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] blk4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    return {packed_word(a), packed_word(b), packed_word(c), packed_word(d)};
  endfunction

  always @(negedge clk) begin
    if (core_ld === 1'b1) begin
      check("ld32_width", 128'(prev_ld), 128'd0);
      check("ld32_busy", 128'(busy), 128'd1);
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL ld32_unexpected: observed core_ld=1 expected no pending block");
      end else begin
        check("blk32", text, q32.pop_front());
      end
    end
    if (core_ld8 === 1'b1) begin
      check("ld8_width", 128'(prev_ld8), 128'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL ld8_unexpected: observed core_ld=1 expected no pending block");
      end else begin
        check("blk8", text8, q8.pop_front());
      end
    end
    prev_ld  = core_ld;
    prev_ld8 = core_ld8;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send32(input logic [31:0] w, input int gap);
    int n;
    bit r, ok;
    bus.in_valid = 1'b0;
    tick(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      r = bus.in_ready;
      tick(1);
      n++;
      ok = r;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL accept32_timeout: observed no accept expected accept within 100 cycles");
    end
  endtask

  task automatic send8(input logic [7:0] w);
    int n;
    bit r, ok;
    bus8.in_valid = 1'b1;
    bus8.in_data  = w;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      r = bus8.in_ready;
      tick(1);
      n++;
      ok = r;
    end
    bus8.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL accept8_timeout: observed no accept expected accept within 100 cycles");
    end
  endtask

  task automatic pulse_done32();
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    core_done = 1'b0;
    core_done8 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus8.in_valid = 1'b0;
    bus8.in_data = '0;
    #1;
    check("rst_ready", 128'(bus.in_ready), 128'd0);
    check("rst_ld", 128'(core_ld), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err_done), 128'd0);
    check("rst_text", text, 128'd0);
    tick(2);
    rst = 1'b0;
    check("ready_before_edge", 128'(bus.in_ready), 128'd0);
    tick(1);
    check("ready_after_edge", 128'(bus.in_ready), 128'd1);
    check("ready8_after_edge", 128'(bus8.in_ready), 128'd1);

    // FIPS-197 block, continuous valid
    q32.push_back(FIPS);
`ifdef AES_TEXT_IN_BYTESWAP_EN
    send32(32'h33221100, 0); send32(32'h77665544, 0);
    send32(32'hbbaa9988, 0); send32(32'hffeeddcc, 0);
`else
    send32(32'h00112233, 0); send32(32'h44556677, 0);
    send32(32'h8899aabb, 0); send32(32'hccddeeff, 0);
`endif
    check("fips_ld", 128'(core_ld), 128'd1);
    check("fips_text", text, FIPS);
    check("fips_ready_low", 128'(bus.in_ready), 128'd0);
    tick(1);
    check("fips_ld_drop", 128'(core_ld), 128'd0);
    check("fips_busy_wait", 128'(busy), 128'd1);
    tick(3);
    check("fips_busy_hold", 128'(busy), 128'd1);
    pulse_done32();
    check("fips_ready_ret", 128'(bus.in_ready), 128'd1);
    check("fips_busy_clear", 128'(busy), 128'd0);
    check("fips_no_err", 128'(err_done), 128'd0);

    // Gaps, then valid held through WAIT and the done edge
    exp_blk = blk4(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    q32.push_back(exp_blk);
    send32(32'h00112233, 2); send32(32'h44556677, 2);
    send32(32'h8899aabb, 2); send32(32'hccddeeff, 2);
    check("gap_ld", 128'(core_ld), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hdeadbeef;
    tick(4);
    check("stall_ready", 128'(bus.in_ready), 128'd0);
    check("stall_text", text, exp_blk);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    check("stall_ready_ret", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b0;
    tick(1);
    check("stall_text_after", text, exp_blk);
    check("stall_no_err", 128'(err_done), 128'd0);

    // Reset after two accepted words
    send32(32'haaaaaaaa, 0);
    send32(32'hbbbbbbbb, 0);
    rst = 1'b1;
    #1;
    check("midrst_text", text, 128'd0);
    check("midrst_ready", 128'(bus.in_ready), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    exp_blk = blk4(32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100);
    q32.push_back(exp_blk);
    send32(32'hffeeddcc, 0); send32(32'hbbaa9988, 0);
    send32(32'h77665544, 0); send32(32'h33221100, 0);
    check("fresh_text", text, exp_blk);
    tick(2);
    pulse_done32();

    // Spurious done during FILL
    pulse_done32();
    check("spur_err", 128'(err_done), 128'd1);
    check("spur_no_busy", 128'(busy), 128'd0);
    check("spur_ready", 128'(bus.in_ready), 128'd1);
    exp_blk = blk4(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
    q32.push_back(exp_blk);
    send32(32'h01234567, 0); send32(32'h89abcdef, 1);
    send32(32'hfedcba98, 0); send32(32'h76543210, 0);
    check("spur_block_text", text, exp_blk);
    tick(1);
    pulse_done32();
    check("spur_err_sticky", 128'(err_done), 128'd1);
    rst = 1'b1;
    #1;
    check("spur_err_rst", 128'(err_done), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);

    // 8-bit instance: 16 bytes 00,11,...,ff
    q8.push_back(FIPS);
    for (int i = 0; i < 16; i++) send8(8'(i * 17));
    check("b8_ld", 128'(core_ld8), 128'd1);
    check("b8_text", text8, FIPS);
    check("b8_busy", 128'(busy8), 128'd1);
    tick(1);
    check("b8_ld_drop", 128'(core_ld8), 128'd0);
    core_done8 = 1'b1;
    tick(1);
    core_done8 = 1'b0;
    check("b8_ready_ret", 128'(bus8.in_ready), 128'd1);

    tick(2);
    check("q32_drained", 128'(q32.size()), 128'd0);
    check("q8_drained", 128'(q8.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
